// File: rtl/result_bus_arbiter.sv
// Round-robin owner arbiter for the 7-way result/writeback mux, with a bounded hold
// time so a requester that keeps asserting cannot starve the others.
//   state | meaning
//   IDLE  | no owner, o_gnt=0, o_sel keeps its last value
//   OWNED | requester o_sel owns the bus, hold_q counts cycles another one waited
module result_bus_arbiter #(
    parameter int N_REQ    = 7,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [3:0]       o_sel,
    output logic             o_valid,
    output logic             o_switch
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [3:0]         sel_q;
    logic               valid_q;
    logic               switch_q;
    logic [CNT_W-1:0]   hold_q;
    logic [3:0]         last_q;

    logic [N_REQ-1:0]   cand;
    logic               win_found;
    logic [3:0]         win_idx;
    logic               owner_req;
    logic               others_req;
    int                 t;

    // gnt_q is zero in IDLE, so excluding it is harmless there and drops the
    // current owner from the search whenever a new owner is being chosen.
    assign owner_req  = |(i_req & gnt_q);
    assign others_req = |(i_req & ~gnt_q);
    assign cand       = i_req & ~gnt_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        t         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            t = int'(last_q) + k;
            if (t >= N_REQ) t = t - N_REQ;
            if (!win_found && cand[t]) begin
                win_found = 1'b1;
                win_idx   = 4'(t);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= 4'd0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            hold_q   <= '0;
            last_q   <= 4'(N_REQ - 1);
        end else begin
            switch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q  <= OWNED;
                        gnt_q    <= N_REQ'(1) << win_idx;
                        sel_q    <= win_idx;
                        valid_q  <= 1'b1;
                        switch_q <= 1'b1;
                        hold_q   <= '0;
                        last_q   <= win_idx;
                    end
                end
                OWNED: begin
                    if (others_req && (!owner_req || hold_q == CNT_W'(MAX_HOLD - 1))) begin
                        gnt_q    <= N_REQ'(1) << win_idx;
                        sel_q    <= win_idx;
                        switch_q <= 1'b1;
                        hold_q   <= '0;
                        last_q   <= win_idx;
                    end else if (!owner_req) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        hold_q  <= '0;
                    end else if (others_req) begin
                        hold_q <= hold_q + 1'b1;
                    end else begin
                        hold_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt    = gnt_q;
    assign o_sel    = sel_q;
    assign o_valid  = valid_q;
    assign o_switch = switch_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed test of result_bus_arbiter: reset, single owner, preemption, rotation,
// wrap of the round-robin pointer and reset during ownership.
module tb_result_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] i_req;
    logic [6:0] o_gnt;
    logic [3:0] o_sel;
    logic       o_valid;
    logic       o_switch;

    int total = 0;
    int bad   = 0;
    int sw_cnt;

    result_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .o_gnt    (o_gnt),
        .o_sel    (o_sel),
        .o_valid  (o_valid),
        .o_switch (o_switch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_req = 7'h00;
        step();
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        i_req = 7'h7F;

        // 1: reset with all requests, then release
        step();
        step();
        chk("rst_gnt",   32'(o_gnt),   32'h0);
        chk("rst_sel",   32'(o_sel),   32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        rst = 1'b0;
        step();
        chk("rel_gnt",    32'(o_gnt),    32'h01);
        chk("rel_sel",    32'(o_sel),    32'h0);
        chk("rel_switch", 32'(o_switch), 32'h1);
        chk("rel_valid",  32'(o_valid),  32'h1);

        // 2: single requester 4 for 10 cycles
        do_reset();
        i_req  = 7'h10;
        sw_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("single_sel", 32'(o_sel), 32'd4);
            chk("single_gnt", 32'(o_gnt), 32'h10);
            if (o_switch) sw_cnt++;
        end
        chk("single_switches", 32'(sw_cnt), 32'd1);
        i_req = 7'h00;
        step();
        chk("idle_valid",  32'(o_valid),  32'h0);
        chk("idle_gnt",    32'(o_gnt),    32'h0);
        chk("idle_sel",    32'(o_sel),    32'd4);
        chk("idle_switch", 32'(o_switch), 32'h0);

        // 3: preemption between 2 and 5
        do_reset();
        i_req = 7'h24;
        step();
        chk("pre_first_sel", 32'(o_sel),    32'd2);
        chk("pre_first_sw",  32'(o_switch), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_hold2_sel", 32'(o_sel),    32'd2);
            chk("pre_hold2_sw",  32'(o_switch), 32'h0);
        end
        step();
        chk("pre_to5_sel", 32'(o_sel),    32'd5);
        chk("pre_to5_gnt", 32'(o_gnt),    32'h20);
        chk("pre_to5_sw",  32'(o_switch), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_hold5_sel", 32'(o_sel),    32'd5);
            chk("pre_hold5_sw",  32'(o_switch), 32'h0);
        end
        step();
        chk("pre_back2_sel", 32'(o_sel),    32'd2);
        chk("pre_back2_sw",  32'(o_switch), 32'h1);

        // 4: rotation, owner drops its request each granted cycle
        do_reset();
        i_req = 7'h7F;
        step();
        chk("rot_sel0", 32'(o_sel), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            i_req = 7'h7F & ~(7'h01 << ((k - 1) % 7));
            step();
            chk("rot_sel",   32'(o_sel),    32'(k % 7));
            chk("rot_gnt",   32'(o_gnt),    32'(7'h01 << (k % 7)));
            chk("rot_sw",    32'(o_switch), 32'h1);
            chk("rot_valid", 32'(o_valid),  32'h1);
        end

        // 5: pointer wrap after granting 6
        i_req = 7'h40;
        step();
        chk("wrap_own6", 32'(o_sel), 32'd6);
        i_req = 7'h00;
        step();
        chk("wrap_idle", 32'(o_valid), 32'h0);
        i_req = 7'h41;
        step();
        chk("wrap_sel", 32'(o_sel), 32'd0);
        chk("wrap_gnt", 32'(o_gnt), 32'h01);

        // 6: reset while 3 owns with hold count 2
        do_reset();
        i_req = 7'h08;
        step();
        chk("mid_own3", 32'(o_sel), 32'd3);
        i_req = 7'h0A;
        step();
        step();
        chk("mid_still3", 32'(o_sel), 32'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_gnt",   32'(o_gnt),   32'h0);
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        rst = 1'b0;
        step();
        chk("mid_after_sel", 32'(o_sel), 32'd1);
        chk("mid_after_gnt", 32'(o_gnt), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
